// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus serial issue/settle/capture sequencer in front of a 4-bit ALU.
// Each command is issued into the ALU, then held until its result is handed off on the valid/ready port.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_op,
  input  logic       cmd_chain,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_x,
  input  logic [3:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_x,
  output logic [3:0] res_y,
  output logic [3:0] res_op,
  output logic       busy,
  output logic [7:0] done_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] SETTLE_W = 4'(SETTLE);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [3:0]    settle_q, settle_d;
  logic [3:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_op_q, alu_op_d;
  logic [3:0]    res_x_q, res_x_d, res_y_q, res_y_d, res_op_q, res_op_d;
  logic [3:0]    last_y_q, last_y_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    done_cnt_q, done_cnt_d;
  logic          full, empty, push, pop;
  logic [12:0]   head;

  // Entry layout: {chain, op, b, a}
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_op_d    = res_op_q;
    last_y_d    = last_y_q;
    res_valid_d = res_valid_q;
    done_cnt_d  = done_cnt_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) begin
          res_x_d     = alu_x;
          res_y_d     = alu_y;
          res_op_d    = alu_op_q;
          last_y_d    = alu_y;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 8'd1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Issue: capture always precedes the next pop, so last_y_q is the preceding result.
    if (pop) begin
      alu_a_d  = head[12] ? last_y_q : head[3:0];
      alu_b_d  = head[7:4];
      alu_op_d = head[11:8];
      settle_d = SETTLE_W;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_chain, cmd_op, cmd_b, cmd_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_op_q    <= '0;
      last_y_q    <= '0;
      res_valid_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_op_q    <= res_op_d;
      last_y_q    <= last_y_d;
      res_valid_q <= res_valid_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign cmd_ready = !full;
  assign busy      = (state_q != S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_op    = res_op_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-issue and result-capture stage sitting directly upstream of `alu4bit`. It buffers operand/opcode commands in a small FIFO and drives the ALU's `a`, `b` and `opcode` inputs from registers. After a programmable settle time it captures the ALU's `x`/`y` outputs and presents them on a valid/ready result port. Operation is strictly serial: one command is in the ALU at a time. An optional chain bit feeds the previous `y` back as operand A.

## Interface

Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `SETTLE`, 1: cycles between driving the ALU inputs and capturing its outputs; 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: FIFO not full.
- `cmd_a`, input, 4: operand A.
- `cmd_b`, input, 4: operand B.
- `cmd_op`, input, 4: ALU opcode.
- `cmd_chain`, input, 1: use last captured `y` as operand A instead of `cmd_a`.
- `alu_a`, output, 4: registered, to ALU `a`.
- `alu_b`, output, 4: registered, to ALU `b`.
- `alu_op`, output, 4: registered, to ALU `opcode`.
- `alu_x`, input, 4: from ALU `x`.
- `alu_y`, input, 4: from ALU `y`.
- `res_valid`, output, 1: result held.
- `res_ready`, input, 1: consumer accepts.
- `res_x`, output, 4: captured ALU `x`.
- `res_y`, output, 4: captured ALU `y`.
- `res_op`, output, 4: opcode that produced the result.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done_cnt`, output, 8: results delivered; wraps 255 to 0.

## Operation

- **Push.** A command is pushed on `cmd_valid && cmd_ready`. `cmd_ready = !full`, computed from registered state only. There is no bypass: a push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
- **FIFO entry.** `{chain, op, b, a}`, 13 bits. Pointers wrap modulo `DEPTH`. An occupancy counter (width log2(DEPTH)+1) determines full and empty.
- **FSM states.** IDLE, WAIT, HOLD.
- **IDLE.**
  - If the FIFO is non-empty: pop the head and load `alu_a` (the `last_y` register if the entry's chain bit is set, else `a`), `alu_b` and `alu_op`.
  - Load the settle counter with `SETTLE`, then go to WAIT.
  - If the FIFO is empty: stay in IDLE.
- **WAIT.**
  - Decrement the settle counter each cycle.
  - On the edge where the counter reaches 0:
    - capture `alu_x`/`alu_y` into `res_x`/`res_y`;
    - copy `alu_op` into `res_op`;
    - copy `alu_y` into `last_y`;
    - set `res_valid`, then go to HOLD.
  - WAIT therefore lasts exactly `SETTLE` cycles.
- **HOLD.**
  - While `res_ready` is 0: `res_*` and `alu_*` are stable and nothing is popped.
  - On `res_ready`: clear `res_valid` and increment `done_cnt`.
  - In the same edge, if the FIFO is non-empty, pop and load the next command and go directly to WAIT. Otherwise go to IDLE.
- **`alu_*` between commands.** They retain their last values.
- **Chaining.** It always sees the immediately preceding result, because capture precedes the next issue. `last_y` resets to 0, so a chained command issued first after reset uses A = 0.
- **Reset** (asynchronous, any state):
  - FIFO flushed; FSM to IDLE.
  - `alu_a`, `alu_b`, `alu_op`, `res_x`, `res_y`, `res_op`, `last_y`, `done_cnt` = 0.
  - `res_valid` = 0, `busy` = 0.
  - `cmd_ready` = 1.
  - Any in-flight result is discarded.

## Timing

- **Best-case latency.** For a command accepted at edge N with the FIFO empty and the FSM in IDLE:
  - the pop happens at edge N+1 and `alu_*` are valid after N+1;
  - the capture happens at edge N+1+SETTLE;
  - `res_valid` is high from N+1+SETTLE.
- **Result hand-off.** The result is transferred at the first edge where `res_valid && res_ready`. A back-to-back next issue occurs at that same edge. Steady-state throughput is one result per SETTLE+1 cycles with `res_ready` tied high.
- **Push into an empty FIFO.** Visible to the FSM one edge later; there is no same-cycle pop of the command being pushed.
- **Wrap-arounds.** `done_cnt` at 255 plus one delivery becomes 0. Pointer wrap must not corrupt ordering.
- **Output timing.** `busy` and `cmd_ready` are pure functions of registered state and have no combinational path from inputs.

## Test plan

The bench drives `alu_x`/`alu_y` from a stub: y = (a+b)[3:0], x = {3'b0, carry}.

1. **Reset.** Hold `rst_n`=0 with random inputs. Required: every output is 0 except `cmd_ready`=1. After release with no commands: `busy`=0.
2. **Single command, SETTLE=1, `res_ready`=1.** Push a=1010, b=0101, op=0000 at edge N. Required:
   - `alu_a`=1010, `alu_b`=0101 after N+1;
   - `res_valid` at N+2 with `res_y`=1111, `res_x`=0000, `res_op`=0000;
   - `done_cnt`=1 after N+3.
3. **Back-pressure, DEPTH=4, `res_ready`=0.** Push commands on consecutive cycles. Required:
   - the 6th command sees `cmd_ready`=0;
   - `res_*` stay frozen on command 1.
   Then raise `res_ready`. Required: results 1..5 arrive in push order with no loss or duplication, and `done_cnt`=5.
4. **Chain.** Push a=0011, b=0100, chain=0, then a=1111, b=0001, chain=1. Required: first `res_y`=0111; second `alu_a`=0111, `res_y`=1000, `res_x`=0000.
5. **Carry with SETTLE=3.** Push a=1111, b=0001 at edge N. Required: `res_valid` first at N+4 (not N+3), `res_y`=0000, `res_x`=0001.
6. **Reset mid-operation.** Pulse `rst_n` low asynchronously during WAIT with 2 commands queued. Required:
   - outputs clear immediately, with no `res_valid` after release;
   - `done_cnt`=0;
   - a subsequent chained command with b=0010 yields `alu_a`=0000 and `res_y`=0010.
